// File: rtl/coriolis_ker1_stream_ctrl.sv
// Run sequencer for the coriolis ker1 sub-kernel stream (source -> kernel -> sink).
// Optional DRAIN stall watchdog with a sticky err port: define CORIOLIS_CTRL_WATCHDOG_EN.
module coriolis_ker1_stream_ctrl #(
  parameter int CNTW   = 24,
  parameter int MAXLAT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] nelem,
  output logic            busy,
  output logic            done,
  input  logic            src_valid,
  output logic            src_ready,
  output logic            ker_ivalid,
  input  logic            ker_iready,
  input  logic            ker_ovalid,
  output logic            ker_oready,
  output logic            snk_valid,
  input  logic            snk_ready,
  output logic [CNTW-1:0] issued,
  output logic [CNTW-1:0] retired
`ifdef CORIOLIS_CTRL_WATCHDOG_EN
  ,
  output logic            err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] len_q, len_d;
  logic [CNTW-1:0] issued_q, issued_d;
  logic [CNTW-1:0] retired_q, retired_d;

  logic            adm;
  logic            oact;
  logic            in_fire;
  logic            out_fire;
  logic [CNTW-1:0] issued_inc;
  logic [CNTW-1:0] retired_inc;
  logic            in_last;
  logic            out_last;

`ifdef CORIOLIS_CTRL_WATCHDOG_EN
  localparam int STALL_LIM = 4 * MAXLAT;
  localparam int STALLW    = (STALL_LIM > 1) ? $clog2(STALL_LIM) : 1;

  logic [STALLW-1:0] stall_q, stall_d;
  logic              err_q, err_d;
`endif

  // Gates are qualified by rst so every handshake output is 0 while reset is held.
  always_comb begin
    adm        = rst && (state_q == S_RUN) && (issued_q < len_q);
    oact       = rst && ((state_q == S_RUN) || (state_q == S_DRAIN));
    ker_ivalid = src_valid & adm;
    src_ready  = ker_iready & adm;
    snk_valid  = ker_ovalid & oact;
    ker_oready = snk_ready & oact;
    in_fire    = src_valid & ker_iready & adm;
    out_fire   = ker_ovalid & snk_ready & oact;
  end

  always_comb begin
    issued_inc  = issued_q + CNTW'(1);
    retired_inc = retired_q + CNTW'(1);
    in_last     = in_fire && (issued_inc == len_q);
    out_last    = out_fire && (retired_inc == len_q);
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = in_fire ? issued_inc : issued_q;
    retired_d = out_fire ? retired_inc : retired_q;
`ifdef CORIOLIS_CTRL_WATCHDOG_EN
    stall_d   = stall_q;
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d     = nelem;
          issued_d  = '0;
          retired_d = '0;
          state_d   = (nelem == '0) ? S_DONE : S_RUN;
`ifdef CORIOLIS_CTRL_WATCHDOG_EN
          err_d     = 1'b0;
`endif
        end
      end

      S_RUN: begin
        // Final input and final output in one cycle skip DRAIN entirely.
        if (in_last) begin
          state_d = out_last ? S_DONE : S_DRAIN;
`ifdef CORIOLIS_CTRL_WATCHDOG_EN
          stall_d = '0;
`endif
        end
      end

      S_DRAIN: begin
        if (out_last) begin
          state_d = S_DONE;
        end
`ifdef CORIOLIS_CTRL_WATCHDOG_EN
        if (out_fire) begin
          stall_d = '0;
        end else if (stall_q == STALLW'(STALL_LIM - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          stall_d = stall_q + STALLW'(1);
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
    end
  end

`ifdef CORIOLIS_CTRL_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign issued  = issued_q;
  assign retired = retired_q;

endmodule

// File: doc/coriolis_ker1_stream_ctrl.md
Name: coriolis_ker1_stream_ctrl

Overview:
- Run-sequencer for the coriolis ker1 sub-kernel pipeline (mul -> div -> xn, with the x buffer alongside).
- Sits between the stream source (memory reader), the sub-kernel's and-ed ivalid/iready pair, and the stream sink (xn writer).
- Latches a job length on start, admits exactly NELEM input tuples, then drains until NELEM outputs have been accepted.
- Raises done when the job is complete; tracks issued and retired counts for the host.

Parameters:
- CNTW, 24, width of element counters and job length.
- MAXLAT, 64, maximum expected pipeline latency in cycles; used only by the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle job start request.
- nelem  in  CNTW  job length; sampled when start is accepted.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; held until the next accepted start.
- src_valid  in  1  source has a tuple (un, x) ready.
- src_ready  out  1  tuple consumed this cycle.
- ker_ivalid  out  1  to the sub-kernel ivalid_un/ivalid_x (both driven identically).
- ker_iready  in  1  sub-kernel iready.
- ker_ovalid  in  1  sub-kernel ovalid.
- ker_oready  out  1  to the sub-kernel oready_xn.
- snk_valid  out  1  xn valid to the sink.
- snk_ready  in  1  sink accepts xn.
- issued  out  CNTW  count of inputs accepted by the kernel this job.
- retired  out  CNTW  count of outputs accepted by the sink this job.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - issued=0, retired=0, stored length=0.
  - busy=0, done=0.
  - All handshake outputs are 0 while in reset.
  - Reset asserted mid-job aborts the job; in-flight kernel data is not tracked further.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE / DONE on start:
  - Latch nelem; clear issued and retired.
  - If nelem=0: go to DONE (done stays or rises, no data moves).
  - Otherwise: go to RUN; done falls in the same edge.
- start in RUN or DRAIN is ignored; the stored length is unchanged.
- Input gate:
  - adm = (state==RUN) and (issued < length).
  - ker_ivalid = src_valid & adm.
  - src_ready = ker_iready & adm.
  - Both are purely combinational; no registered bubble.
- Input fire = src_valid & ker_iready & adm; issued increments by 1 on each fire.
- Output gate:
  - oact = state in {RUN, DRAIN}.
  - snk_valid = ker_ovalid & oact.
  - ker_oready = snk_ready & oact.
- Output fire = ker_ovalid & snk_ready & oact; retired increments by 1 on each fire.
- Input and output fires in the same cycle both count.
- RUN -> DRAIN when an input fire brings issued to length.
- RUN -> DONE directly when, in the same cycle, the final input fire and the final output fire both occur (retired reaches length).
- DRAIN -> DONE when an output fire brings retired to length.
- Invariant: retired <= issued <= length. Counters never wrap; CNTW must cover the maximum job.
- The kernel's ovalid in IDLE/DONE is not forwarded and not acknowledged; any such data stalls in the kernel.
- Output latency: busy, done and the counters are registered, updating one edge after the causing event. Handshake outputs are combinational from state and inputs.

Optional Feature:
- Macro: CORIOLIS_CTRL_WATCHDOG_EN.
- When defined:
  - A stall counter counts consecutive DRAIN cycles without an output fire.
  - If it reaches 4*MAXLAT: go to DONE and set sticky output err (1 bit, added port).
  - err clears on the next accepted start or on reset.
  - The stall counter clears on each output fire and on entry to DRAIN.
- When undefined: no err port and no stall counter; DRAIN waits indefinitely.

Test Plan:
- Reset, then start with nelem=8, src_valid=1, ker_iready=1, snk_ready=1, kernel latency 5:
  - issued reaches 8 after 8 cycles; state goes to DRAIN.
  - retired reaches 8; done=1; busy=0.
- start with nelem=0 -> DONE the next cycle; issued=0 and retired=0; no src_ready pulse.
- nelem=16, src_valid toggling 1010..., snk_ready stuck at 0 for 20 cycles and then 1:
  - No output fire while snk_ready=0; ker_oready=0 throughout that window.
  - Final counts are 16/16.
  - src_ready never asserts after issued reaches 16.
- Second start pulsed during RUN of a nelem=10 job -> ignored; job ends at 10/10; then a new start with nelem=3 clears done and completes at 3/3.
- rst driven low at the 4th input of a nelem=10 job -> next edge: IDLE, counters 0, busy=0, done=0.
- With CORIOLIS_CTRL_WATCHDOG_EN and MAXLAT=4: withhold ker_ovalid after 2 of 4 outputs -> err=1 and DONE after 16 stall cycles.
